// File: rtl/bet_pkg.sv
// Shared types and constants for the baccarat betting ledger.
// Holds the ledger FSM state encoding, bet-side and round-result codes,
// the payout datapath width, and a saturating 8-bit narrowing helper.
package bet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BETTING = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CREDIT  = 3'd4
  } state_e;

  // Side the player has wagered on.
  localparam logic [1:0] SIDE_NONE   = 2'b00;
  localparam logic [1:0] SIDE_PLAYER = 2'b01;
  localparam logic [1:0] SIDE_DEALER = 2'b10;
  localparam logic [1:0] SIDE_TIE    = 2'b11;

  // Round outcome, encoded as {player_win, dealer_win}.
  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b10;
  localparam logic [1:0] RES_DEALER = 2'b01;
  localparam logic [1:0] RES_TIE    = 2'b11;

  // Width of the payout path: a full 255 stake on a tie at the largest
  // multiple still fits without wrapping.
  localparam int PAY_W = 12;

  // Clamp a payout-width sum to the 8-bit bankroll.
  function automatic logic [7:0] sat8(input logic [PAY_W-1:0] v);
    return (v > PAY_W'(255)) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/bet_payout.sv
// Combinational settlement: maps the locked stake, bet side and final hand
// scores to the round result and the amount returned to the bankroll.
// BANKER_COMMISSION_EN: when defined, a winning dealer-side bet is charged
// a house commission of floor(stake/16); otherwise it pays 2 x stake.
module bet_payout
  import bet_pkg::*;
#(
  parameter logic [3:0] TIE_MULT = 4'd8
) (
  input  logic [7:0]       stake,
  input  logic [1:0]       side,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  output logic [PAY_W-1:0] payout,
  output logic [1:0]       result
);

  // Tie bets return the stake plus TIE_MULT times the stake.
  localparam logic [PAY_W-1:0] TIE_FACTOR = PAY_W'(TIE_MULT) + PAY_W'(1);

  logic [PAY_W-1:0] stake_w;
  logic [PAY_W-1:0] win_pay;
  logic [PAY_W-1:0] dealer_pay;
  logic [PAY_W-1:0] tie_pay;

  // Decide the winner and select the payout for the wagered side.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    result     = RES_TIE;
    payout     = '0;
    stake_w    = PAY_W'(stake);
    win_pay    = stake_w << 1;
    tie_pay    = stake_w * TIE_FACTOR;
`ifdef BANKER_COMMISSION_EN
    dealer_pay = win_pay - (stake_w >> 4);
`else
    dealer_pay = win_pay;
`endif

    if (pscore > dscore) begin
      result = RES_PLAYER;
    end else if (pscore < dscore) begin
      result = RES_DEALER;
    end

    unique case (result)
      RES_PLAYER: if (side == SIDE_PLAYER) payout = win_pay;
      RES_DEALER: if (side == SIDE_DEALER) payout = dealer_pay;
      RES_TIE: begin
        if (side == SIDE_TIE) begin
          payout = tie_pay;
        end else if (side != SIDE_NONE) begin
          payout = stake_w;  // push: stake handed back
        end
      end
      default: payout = '0;
    endcase
  end

endmodule

// File: rtl/bet_ledger.sv
// Betting and balance datapath for the baccarat table.
// Accumulates the wager while the bet window is open, debits it on lock,
// settles from the final scores and credits the bankroll with saturation.
// BANKER_COMMISSION_EN (see bet_payout) selects dealer-win commission.
module bet_ledger
  import bet_pkg::*;
#(
  parameter logic [7:0] INIT_BALANCE = 8'd100,
  parameter logic [7:0] BET_STEP     = 8'd5,
  parameter logic [3:0] TIE_MULT     = 4'd8
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       betenabled,
  input  logic       updatebalanceenable,
  input  logic       bet_inc,
  input  logic [1:0] bet_side,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [7:0] balance,
  output logic [7:0] bet_amount,
  output logic [1:0] result,
  output logic       settle_done,
  output logic       broke
);

  state_e           state_q, state_d;
  logic [7:0]       balance_q, balance_d;
  logic [7:0]       bet_amount_q, bet_amount_d;
  logic [1:0]       side_q, side_d;
  logic [1:0]       result_q, result_d;
  logic [PAY_W-1:0] payout_q, payout_d;
  logic             settle_done_q, settle_done_d;

  logic [8:0]       bet_next;
  logic [PAY_W-1:0] credit_sum;
  logic [PAY_W-1:0] calc_payout;
  logic [1:0]       calc_result;

  bet_payout #(
    .TIE_MULT (TIE_MULT)
  ) u_payout (
    .stake  (bet_amount_q),
    .side   (side_q),
    .pscore (pscore),
    .dscore (dscore),
    .payout (calc_payout),
    .result (calc_result)
  );

  // Next-state and datapath updates for each phase of the round.
  always_comb begin
    state_d       = state_q;
    balance_d     = balance_q;
    bet_amount_d  = bet_amount_q;
    side_d        = side_q;
    result_d      = result_q;
    payout_d      = payout_q;
    settle_done_d = 1'b0;
    // 9-bit so a wager near 255 cannot wrap past the bankroll cap.
    bet_next      = {1'b0, bet_amount_q} + {1'b0, BET_STEP};
    credit_sum    = PAY_W'(balance_q) + payout_q;

    unique case (state_q)
      ST_IDLE: begin
        bet_amount_d = '0;
        side_d       = SIDE_NONE;
        if (betenabled) state_d = ST_BETTING;
      end
      ST_BETTING: begin
        side_d = bet_side;
        if (betenabled) begin
          // Increments that would exceed the bankroll are dropped.
          if (bet_inc && (bet_next <= {1'b0, balance_q})) begin
            bet_amount_d = bet_next[7:0];
          end
        end else begin
          state_d   = ST_LOCKED;
          balance_d = balance_q - bet_amount_q;
          result_d  = RES_NONE;
        end
      end
      ST_LOCKED: begin
        if (updatebalanceenable) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        result_d = calc_result;
        payout_d = calc_payout;
        state_d  = ST_CREDIT;
      end
      ST_CREDIT: begin
        balance_d     = sat8(credit_sum);
        bet_amount_d  = '0;
        side_d        = SIDE_NONE;
        settle_done_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; a stake in flight is forfeited.
  always_ff @(posedge slow_clock) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    if (reset) begin
      state_q       <= ST_IDLE;
      balance_q     <= INIT_BALANCE;
      bet_amount_q  <= '0;
      side_q        <= SIDE_NONE;
      result_q      <= RES_NONE;
      payout_q      <= '0;
      settle_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      bet_amount_q  <= bet_amount_d;
      side_q        <= side_d;
      result_q      <= result_d;
      payout_q      <= payout_d;
      settle_done_q <= settle_done_d;
    end
  end

  assign balance     = balance_q;
  assign bet_amount  = bet_amount_q;
  assign result      = result_q;
  assign settle_done = settle_done_q;
  assign broke       = (state_q == ST_IDLE) && (balance_q == 8'd0);

endmodule

// File: tb/tb_bet_ledger.sv
// Self-checking bench for bet_ledger. Two instances (bankroll 100 and 200)
// share one stimulus stream; a round-level reference model predicts each
// settlement, and a monitor pops the prediction whenever settle_done fires.
module tb_bet_ledger;

  localparam int STEP       = 5;
  localparam int INIT0      = 100;
  localparam int INIT1      = 200;
  localparam int TIE_FACTOR = 9;

  typedef struct {
    int result;
    int balance;
  } exp_t;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic       betenabled = 1'b0;
  logic       updatebalanceenable = 1'b0;
  logic       bet_inc = 1'b0;
  logic [1:0] bet_side = 2'b00;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;

  logic [7:0] balance_o    [2];
  logic [7:0] bet_amount_o [2];
  logic [1:0] result_o     [2];
  logic       settle_o     [2];
  logic       broke_o      [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int         bal_m   [2];
  int         stake_m [2];
  int         res_m;
  logic [1:0] side_m;
  exp_t       sb0[$];
  exp_t       sb1[$];

  always #5 slow_clock = ~slow_clock;

  bet_ledger #(.INIT_BALANCE(8'd100)) dut0 (
    .slow_clock          (slow_clock),
    .reset               (reset),
    .betenabled          (betenabled),
    .updatebalanceenable (updatebalanceenable),
    .bet_inc             (bet_inc),
    .bet_side            (bet_side),
    .pscore              (pscore),
    .dscore              (dscore),
    .balance             (balance_o[0]),
    .bet_amount          (bet_amount_o[0]),
    .result              (result_o[0]),
    .settle_done         (settle_o[0]),
    .broke               (broke_o[0])
  );

  bet_ledger #(.INIT_BALANCE(8'd200)) dut1 (
    .slow_clock          (slow_clock),
    .reset               (reset),
    .betenabled          (betenabled),
    .updatebalanceenable (updatebalanceenable),
    .bet_inc             (bet_inc),
    .bet_side            (bet_side),
    .pscore              (pscore),
    .dscore              (dscore),
    .balance             (balance_o[1]),
    .bet_amount          (bet_amount_o[1]),
    .result              (result_o[1]),
    .settle_done         (settle_o[1]),
    .broke               (broke_o[1])
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_amt(input int bal, input int n);
    int k;
    k = bal / STEP;
    return ((n < k) ? n : k) * STEP;
  endfunction

  function automatic int exp_res(input int ps, input int ds);
    if (ps > ds) return 2;
    if (ps < ds) return 1;
    return 3;
  endfunction

  function automatic int exp_pay(input int s, input logic [1:0] side, input int res);
    if (side == 2'b00) return 0;
    if (res == 3) return (side == 2'b11) ? s * TIE_FACTOR : s;
    if (res == 2 && side == 2'b01) return 2 * s;
    if (res == 1 && side == 2'b10) begin
`ifdef BANKER_COMMISSION_EN
      return 2 * s - s / 16;
`else
      return 2 * s;
`endif
    end
    return 0;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge slow_clock) begin
    exp_t e;
    if (settle_o[0]) begin
      if (sb0.size() == 0) check("dut0_spurious_settle", 1, 0);
      else begin
        e = sb0.pop_front();
        check("dut0_settle_result", int'(result_o[0]), e.result);
        check("dut0_settle_balance", int'(balance_o[0]), e.balance);
      end
    end
    if (settle_o[1]) begin
      if (sb1.size() == 0) check("dut1_spurious_settle", 1, 0);
      else begin
        e = sb1.pop_front();
        check("dut1_settle_result", int'(result_o[1]), e.result);
        check("dut1_settle_balance", int'(balance_o[1]), e.balance);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; betenabled = 1'b0; bet_inc = 1'b0; updatebalanceenable = 1'b0;
    tick();
    reset = 1'b0;
    bal_m[0] = INIT0; bal_m[1] = INIT1; res_m = 0;
    @(negedge slow_clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_rst_balance", d), int'(balance_o[d]), bal_m[d]);
      check($sformatf("dut%0d_rst_bet", d), int'(bet_amount_o[d]), 0);
      check($sformatf("dut%0d_rst_result", d), int'(result_o[d]), 0);
      check($sformatf("dut%0d_rst_settle", d), int'(settle_o[d]), 0);
      check($sformatf("dut%0d_rst_broke", d), int'(broke_o[d]), 0);
    end
  endtask

  // Open the window, issue n back-to-back bet_inc pulses, check the wager.
  task automatic open_and_bet(input int n, input logic [1:0] side, input bit noise);
    @(negedge slow_clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_idle_bet", d), int'(bet_amount_o[d]), 0);
      check($sformatf("dut%0d_result_held", d), int'(result_o[d]), res_m);
    end
    side_m = side; bet_side = side; betenabled = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      bet_inc = 1'b1;
      if (noise) updatebalanceenable = 1'($urandom_range(0, 1));
      tick();
    end
    bet_inc = 1'b0; updatebalanceenable = 1'b0;
    @(negedge slow_clock);
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d_wager", d), int'(bet_amount_o[d]), exp_amt(bal_m[d], n));
  endtask

  // Close the window (optionally with a pulse that must be dropped).
  task automatic lock(input int n, input bit drop);
    betenabled = 1'b0; bet_inc = drop;
    tick();
    bet_inc = 1'b0;
    @(negedge slow_clock);
    for (int d = 0; d < 2; d++) begin
      stake_m[d] = exp_amt(bal_m[d], n);
      bal_m[d]   = bal_m[d] - stake_m[d];
      check($sformatf("dut%0d_lock_balance", d), int'(balance_o[d]), bal_m[d]);
      check($sformatf("dut%0d_lock_bet", d), int'(bet_amount_o[d]), stake_m[d]);
    end
  endtask

  // Idle in LOCKED with ignored inputs, then request settlement for hold cycles.
  task automatic settle(input int ps, input int ds, input int hold, input int lw);
    exp_t e;
    for (int i = 0; i < lw; i++) begin
      betenabled = 1'b1; bet_inc = 1'($urandom_range(0, 1));
      tick();
    end
    betenabled = 1'b0; bet_inc = 1'b0;
    pscore = 4'(ps); dscore = 4'(ds);
    res_m = exp_res(ps, ds);
    for (int d = 0; d < 2; d++) begin
      e.result  = res_m;
      e.balance = bal_m[d] + exp_pay(stake_m[d], side_m, res_m);
      if (e.balance > 255) e.balance = 255;
      bal_m[d] = e.balance;
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    updatebalanceenable = 1'b1;
    repeat (hold) tick();
    updatebalanceenable = 1'b0;
    for (int i = 0; i < 20 && (sb0.size() != 0 || sb1.size() != 0); i++) tick();
    check("settle_within_bound", sb0.size() + sb1.size(), 0);
    sb0.delete(); sb1.delete();
    @(negedge slow_clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_post_bet", d), int'(bet_amount_o[d]), 0);
      check($sformatf("dut%0d_post_broke", d), int'(broke_o[d]), (bal_m[d] == 0) ? 1 : 0);
    end
  endtask

  task automatic do_round(input int n, input logic [1:0] side, input int ps, input int ds,
                          input bit drop, input int hold, input int lw, input bit noise);
    open_and_bet(n, side, noise);
    lock(n, drop);
    settle(ps, ds, hold, lw);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Player win: 20 on player, 9 vs 3.
    do_round(4, 2'b01, 9, 3, 1'b0, 1, 0, 1'b0);
    // Dealer win: 20 on dealer, 2 vs 7.
    apply_reset();
    do_round(4, 2'b10, 2, 7, 1'b0, 1, 0, 1'b0);
    // Tie bet on a tie, then a push.
    apply_reset();
    do_round(2, 2'b11, 6, 6, 1'b0, 1, 0, 1'b0);
    apply_reset();
    do_round(4, 2'b01, 5, 5, 1'b0, 1, 0, 1'b0);
    // Cap at the bankroll, dropped pulse on the closing cycle, long request.
    apply_reset();
    do_round(25, 2'b10, 1, 8, 1'b1, 5, 2, 1'b1);
    // Saturation: maximum tie stake.
    apply_reset();
    do_round(40, 2'b11, 4, 4, 1'b0, 1, 0, 1'b0);
    // Go broke, then bet against an empty bankroll; a no-side round too.
    apply_reset();
    do_round(20, 2'b01, 2, 8, 1'b0, 1, 0, 1'b0);
    do_round(5, 2'b01, 7, 1, 1'b1, 2, 1, 1'b0);
    do_round(3, 2'b00, 7, 1, 1'b0, 1, 0, 1'b0);

    // Reset while LOCKED forfeits the stake; a lone request does nothing.
    apply_reset();
    open_and_bet(10, 2'b01, 1'b0);
    lock(10, 1'b0);
    apply_reset();
    updatebalanceenable = 1'b1;
    repeat (3) tick();
    updatebalanceenable = 1'b0;
    repeat (3) tick();
    @(negedge slow_clock);
    check("dut0_after_lone_request", int'(balance_o[0]), INIT0);
    check("dut1_after_lone_request", int'(balance_o[1]), INIT1);

    // Randomised rounds.
    for (int r = 0; r < 40; r++) begin
      int ps, ds;
      ps = int'($urandom_range(0, 9));
      ds = ($urandom_range(0, 3) == 0) ? ps : int'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) apply_reset();
      do_round(int'($urandom_range(0, 25)), 2'($urandom_range(0, 3)), ps, ds,
               1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bet_ledger.md
# bet_ledger

Betting and balance datapath for the baccarat table; the counterpart of the game-sequencing controller. The controller drives `betenabled` and `updatebalanceenable`, and this block answers both. While `betenabled` is open it accumulates the wager and side from the player buttons, debits the stake when the window closes, then settles the round from the final scores and publishes the updated `balance` that the controller reads to decide game-over.

## Interface
Parameters:
- INIT_BALANCE, 8'd100, balance loaded on reset
- BET_STEP, 8'd5, wager increment per `bet_inc` pulse
- TIE_MULT, 4'd8, tie payout multiple (winnings = stake × TIE_MULT, plus stake returned)

Ports:
- slow_clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- betenabled  in  1  level from controller; high = bet window open
- updatebalanceenable  in  1  level from controller; request to settle the round
- bet_inc  in  1  one-cycle pulse; add BET_STEP to the wager
- bet_side  in  2  01 player, 10 dealer, 11 tie, 00 no bet
- pscore, dscore  in  4 each  final hand scores, valid while updatebalanceenable is high
- balance  out  8  current bankroll
- bet_amount  out  8  current/locked wager
- result  out  2  {player_win, dealer_win}; 11 = tie; held until the next lock
- settle_done  out  1  one-cycle pulse after the balance is credited
- broke  out  1  high when balance == 0 in IDLE

## Operation
States: IDLE, BETTING, LOCKED, SETTLE, CREDIT.
- IDLE: bet_amount = 0, side register = 00.
  - betenabled = 1 → BETTING.
  - updatebalanceenable is ignored.
- BETTING: on each cycle
  - side register ← bet_side.
  - On bet_inc: bet_amount += BET_STEP only if bet_amount + BET_STEP ≤ balance (9-bit compare); otherwise the pulse is dropped.
  - betenabled = 0 → LOCKED, with balance ← balance − bet_amount on the same edge. Underflow is impossible because of the cap.
- LOCKED: bet_amount and side are frozen.
  - bet_inc and betenabled are ignored.
  - updatebalanceenable = 1 → SETTLE.
- SETTLE: register result from scores: pscore > dscore → 10; < → 01; = → 11.
  - Register a 12-bit payout:
    - Side matches winner (player/dealer): 2 × stake.
    - Tie side on tie outcome: stake × (TIE_MULT + 1).
    - Player/dealer side on tie outcome (push): stake.
    - Side 00, or any losing side: 0.
  - Next state → CREDIT.
- CREDIT: balance ← min(balance + payout, 255) using 12-bit arithmetic. Next state → IDLE; settle_done = 1 for exactly the following cycle.
- Reset at any point: balance = INIT_BALANCE. Any stake in flight is lost and never refunded.

## Timing
- Reset values: balance = INIT_BALANCE, bet_amount = 0, result = 00, settle_done = 0, broke = (INIT_BALANCE == 0), state = IDLE.
- Lock: the debit is visible one cycle after the first sampled betenabled = 0.
- Settle latency: updatebalanceenable sampled high at edge N in LOCKED.
  - Edge N+1: payout and result are registered.
  - Edge N+2: balance is updated.
  - Cycle after N+2: settle_done is high.
- Simultaneous events:
  - bet_inc in the cycle betenabled falls: dropped.
  - updatebalanceenable during BETTING: ignored.
  - updatebalanceenable still high on return to IDLE: no second settlement.
- Zero stake (bet_amount 0 or side 00) still walks SETTLE/CREDIT, with payout 0.

## Configuration
- BANKER_COMMISSION_EN defined: a winning dealer-side bet pays 2 × stake − (stake >> 4), i.e. a house commission of floor(stake/16).
- Undefined: dealer wins pay 2 × stake, exactly like player wins.
- Ties and pushes are unaffected either way.

## Structure
- Package bet_pkg holds:
  - state encoding enum
  - side codes: SIDE_NONE, SIDE_PLAYER, SIDE_DEALER, SIDE_TIE
  - result codes: RES_PLAYER = 2'b10, RES_DEALER = 2'b01, RES_TIE = 2'b11
  - payout width constant PAY_W = 12
- One sub-module, bet_payout: combinational. It maps (stake, side, pscore, dscore) to (payout, result) and owns the commission macro.

## Test plan
- Player win: reset, betenabled high, 4 bet_inc pulses, side 01, betenabled low. Expect balance 80. Then scores 9/3 with updatebalanceenable → result 10, balance 120, one settle_done pulse.
- Dealer win: bet 20, side 10, scores 2/7. Expect balance 119 with BANKER_COMMISSION_EN, 120 without.
- Tie bet and push:
  - Tie: bet 10, side 11, scores 6/6 → lock at 90, final 180.
  - Push: bet 20, side 01, scores 5/5 → final 100.
- Cap and simultaneity:
  - 25 bet_inc pulses → bet_amount stops at 100.
  - A pulse on the betenabled-falling cycle is dropped.
  - Holding updatebalanceenable high for 5 cycles settles exactly once.
- Saturation: INIT_BALANCE 200, bet 200 on tie, scores 4/4 → payout 1800, balance 255.
- Reset mid-LOCKED after a 50 debit → balance 100, bet_amount 0, result 00, state IDLE; a later updatebalanceenable alone changes nothing.
